// File: rtl/sd_sector_responder.sv
// sd_sector_responder: answers sd_rd/sd_wr sector requests, moving 256 words between the sd_buff port and word storage.
// Define SD_RESP_BOUNDS_EN to add size_sectors; out-of-range sectors are acked but never touch storage.
module sd_sector_responder #(
    parameter int LBA_BITS = 15,
    parameter int DIN_LAT  = 2
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic [31:0]           sd_lba,
    input  logic                  sd_rd,
    input  logic                  sd_wr,
    output logic                  sd_ack,
    output logic [7:0]            sd_buff_addr,
    output logic [15:0]           sd_buff_dout,
    input  logic [15:0]           sd_buff_din,
    output logic                  sd_buff_wr,
    output logic [LBA_BITS+7:0]   st_addr,
    output logic                  st_rd,
    output logic                  st_wr,
    output logic [15:0]           st_wdata,
    input  logic [15:0]           st_rdata,
    input  logic                  st_ready
`ifdef SD_RESP_BOUNDS_EN
    ,
    input  logic [LBA_BITS:0]     size_sectors
`endif
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_PUT, WR_ADDR, WR_REQ, DONE} state_t;
    state_t              state_q;
    logic [LBA_BITS-1:0] lba_q;
    logic [7:0]          idx_q, buff_addr_q, nidx;
    logic [1:0]          cnt_q;
    logic                go_q, oor_q, ack_q, buff_wr_q, st_rd_q, st_wr_q, oor_in, unused_lba;
    logic [15:0]         dout_q, wdata_q;
    logic [LBA_BITS+7:0] st_addr_q;

`ifdef SD_RESP_BOUNDS_EN
    assign oor_in = sd_lba >= 32'(size_sectors);
`else
    assign oor_in = 1'b0;
`endif
    assign unused_lba   = ^sd_lba[31:LBA_BITS];
    assign nidx         = idx_q + 8'd1;
    assign sd_ack       = ack_q;
    assign sd_buff_addr = buff_addr_q;
    assign sd_buff_dout = dout_q;
    assign sd_buff_wr   = buff_wr_q;
    assign st_addr      = st_addr_q;
    assign st_rd        = st_rd_q;
    assign st_wr        = st_wr_q;
    assign st_wdata     = wdata_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            lba_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            go_q        <= 1'b0;
            oor_q       <= 1'b0;
            ack_q       <= 1'b0;
            buff_wr_q   <= 1'b0;
            st_rd_q     <= 1'b0;
            st_wr_q     <= 1'b0;
            buff_addr_q <= '0;
            dout_q      <= '0;
            wdata_q     <= '0;
            st_addr_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (sd_rd || sd_wr) begin
                    lba_q       <= sd_lba[LBA_BITS-1:0];
                    oor_q       <= oor_in;
                    idx_q       <= '0;
                    cnt_q       <= '0;
                    buff_addr_q <= '0;
                    ack_q       <= 1'b1;
                    state_q     <= sd_rd ? RD_REQ : WR_ADDR;
                end
                // go_q marks that the current word's storage request has been issued
                RD_REQ: if (!go_q) begin
                    go_q      <= 1'b1;
                    st_rd_q   <= !oor_q;
                    st_addr_q <= {lba_q, idx_q};
                end else if (oor_q || st_ready) begin
                    go_q        <= 1'b0;
                    st_rd_q     <= 1'b0;
                    dout_q      <= oor_q ? 16'h0000 : st_rdata;
                    buff_addr_q <= idx_q;
                    buff_wr_q   <= 1'b1;
                    state_q     <= RD_PUT;
                end
                RD_PUT: begin
                    buff_wr_q <= 1'b0;
                    if (idx_q == 8'hff) state_q <= DONE;
                    else begin
                        idx_q     <= nidx;
                        go_q      <= 1'b1;
                        st_rd_q   <= !oor_q;
                        st_addr_q <= {lba_q, nidx};
                        state_q   <= RD_REQ;
                    end
                end
                WR_ADDR: if (cnt_q == 2'(DIN_LAT)) begin
                    wdata_q   <= sd_buff_din;
                    st_wr_q   <= !oor_q;
                    st_addr_q <= {lba_q, idx_q};
                    state_q   <= WR_REQ;
                end else cnt_q <= cnt_q + 2'd1;
                WR_REQ: if (oor_q || st_ready) begin
                    st_wr_q <= 1'b0;
                    cnt_q   <= '0;
                    if (idx_q == 8'hff) state_q <= DONE;
                    else begin
                        idx_q       <= nidx;
                        buff_addr_q <= nidx;
                        state_q     <= WR_ADDR;
                    end
                end
                DONE: begin
                    ack_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_sector_responder.sv
// tb_sd_sector_responder: randomized bench with a transfer-level storage/buffer model and per-cycle output checks.
module tb_sd_sector_responder;
    logic        clk_sys = 0, reset_n = 0;
    logic [31:0] sd_lba = 0;
    logic        sd_rd = 0, sd_wr = 0;
    logic        sd_ack, sd_buff_wr, st_rd, st_wr;
    logic [7:0]  sd_buff_addr;
    logic [15:0] sd_buff_dout, sd_buff_din, st_wdata;
    logic [22:0] st_addr;
    logic [15:0] st_rdata = 0;
    logic        st_ready = 0;
`ifdef SD_RESP_BOUNDS_EN
    logic [15:0] size_sectors = 16;
`endif

    always #5 clk_sys = ~clk_sys;

    sd_sector_responder dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr), .st_addr(st_addr), .st_rd(st_rd),
        .st_wr(st_wr), .st_wdata(st_wdata), .st_rdata(st_rdata), .st_ready(st_ready)
`ifdef SD_RESP_BOUNDS_EN
        , .size_sectors(size_sectors)
`endif
    );

    int errors = 0, checks = 0;
    logic [15:0] mem [int];
    logic [15:0] rbuf [256];
    logic [15:0] wbuf [256];
    logic [15:0] d1 = 0, d2 = 0;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    function automatic logic [15:0] mrd(input int a);
        logic [31:0] v = a;
        return mem.exists(a) ? mem[a] : (v[15:0] ^ 16'h3C3C);
    endfunction

    // buffer with a two-cycle read latency from sd_buff_addr to sd_buff_din
    always @(posedge clk_sys) begin
        d1 <= wbuf[sd_buff_addr];
        d2 <= d1;
    end
    assign sd_buff_din = d2;

    int rmode = 0, wait_n = 0, wcnt = 0;
    bit active = 0, kind_rd = 0, oor = 0, hs_rd, hs_wr;
    bit p_ack = 0, p_rd = 0, pp_rd = 0, pp_wr = 0;
    logic [31:0] p_lba = 0;
    logic [22:0] p_st_addr = 0;
    logic [15:0] p_wdata = 0;
    int lba_base = 0, wk = 0, nreq = 0, alen = 0, gap = 0;
    int last_alen = 0, last_words = 0, last_nreq = 0, last_gap = 0, ndone = 0;
    bit last_kind = 0;

    always @(negedge clk_sys) begin
        if (!reset_n) begin
            active = 0; pp_rd = 0; pp_wr = 0; wcnt = 0; p_ack = 0; gap = 0; st_ready = 0;
        end else begin
            if (st_rd || st_wr) begin
                if (wcnt >= wait_n) st_ready = 1;
                else begin st_ready = 0; wcnt++; end
            end else st_ready = (rmode == 0) ? 1'b1 : (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            st_rdata = (st_ready && st_rd) ? mrd(int'(st_addr)) : 16'($urandom);
            hs_rd = st_rd && st_ready;
            hs_wr = st_wr && st_ready;
            if (hs_rd || hs_wr) begin
                wcnt = 0;
                wait_n = (rmode == 0) ? 0 : (rmode == 1) ? 5 : int'($urandom_range(0, 3));
            end
            if (sd_ack && !p_ack) begin
                active = 1; kind_rd = p_rd; lba_base = int'(p_lba & 32'h7FFF) << 8;
`ifdef SD_RESP_BOUNDS_EN
                oor = p_lba >= 32'(size_sectors);
`else
                oor = 0;
`endif
                wk = 0; nreq = 0; alen = 0; last_gap = gap;
            end
            if (!sd_ack && p_ack) begin
                last_alen = alen; last_words = wk; last_nreq = nreq; last_kind = kind_rd; ndone++;
                if (kind_rd || !oor) chk("words_per_sector", wk, 256);
                chk("storage_requests", nreq, oor ? 0 : 256);
                active = 0; gap = 0;
            end
            if (sd_ack) alen++; else gap++;
            if (!sd_ack) chk("idle_outputs", {st_rd, st_wr, sd_buff_wr}, 0);
            if (active && kind_rd) begin
                chk("rd_no_st_wr", st_wr, 0);
                if (hs_rd) begin
                    chk("rd_st_addr", st_addr, 64'(lba_base + wk));
                    nreq++;
                end
                if (sd_buff_wr) begin
                    chk("rd_buff_addr", sd_buff_addr, 64'(wk));
                    chk("rd_buff_dout", sd_buff_dout, oor ? 16'h0000 : mrd(lba_base + wk));
                    rbuf[sd_buff_addr] = sd_buff_dout;
                    wk++;
                end
            end else if (active) begin
                chk("wr_no_rd_strobe", {st_rd, sd_buff_wr}, 0);
                if (hs_wr) begin
                    chk("wr_st_addr", st_addr, 64'(lba_base + wk));
                    chk("wr_st_wdata", st_wdata, wbuf[wk[7:0]]);
                    mem[int'(st_addr)] = st_wdata;
                    nreq++; wk++;
                end
            end
            if (pp_rd) chk("st_rd_held", {st_rd, st_addr}, {1'b1, p_st_addr});
            if (pp_wr) chk("st_wr_held", {st_wr, st_addr, st_wdata}, {1'b1, p_st_addr, p_wdata});
            pp_rd = st_rd && !hs_rd; pp_wr = st_wr && !hs_wr;
            p_st_addr = st_addr; p_wdata = st_wdata;
            p_ack = sd_ack; p_rd = sd_rd; p_lba = sd_lba;
        end
    end

    task automatic set_mode(input int m);
        rmode = m; wait_n = (m == 1) ? 5 : 0; wcnt = 0;
    endtask

    task automatic wait_ack();
        int n = 0;
        while (!sd_ack && n < 100) begin @(posedge clk_sys); #1; n++; end
        chk("ack_rise_timeout", sd_ack, 1);
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (ndone < target && n < 6000) begin @(negedge clk_sys); #1; n++; end
        chk("done_timeout", ndone >= target, 1);
    endtask

    task automatic run(input bit r, input bit w, input logic [31:0] l);
        int target = ndone + 1;
        for (int k = 0; k < 256; k++) rbuf[k] = 16'hFFFF;
        @(posedge clk_sys); #1;
        sd_rd = r; sd_wr = w; sd_lba = l;
        wait_ack();
        sd_rd = 0; sd_wr = 0; sd_lba = $urandom;
        wait_done(target);
    endtask

    initial begin
        int target, save, n;
        bit r, exp_oor;
        logic [31:0] l;
        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_ack", sd_ack, 0);
        chk("rst_strobe", sd_buff_wr, 0);
        chk("rst_st_req", {st_rd, st_wr}, 0);
        chk("rst_addrs", {sd_buff_addr, st_addr}, 0);
        chk("rst_data", {sd_buff_dout, st_wdata}, 0);
        reset_n = 1;

        for (int k = 0; k < 256; k++) mem[3 * 256 + k] = 16'hA500 + 16'(k);
        set_mode(0);
        run(1, 0, 3);
        chk("t1_ack_len", last_alen, 514);
        chk("t1_kind", last_kind, 1);
        for (int k = 0; k < 256; k++) chk("t1_data", rbuf[k], 16'hA500 + 16'(k));

        for (int k = 0; k < 256; k++) wbuf[k] = 16'h1000 + 16'(k);
        run(0, 1, 7);
        chk("t2_ack_len", last_alen, 1025);
        chk("t2_st_wr_count", last_nreq, 256);
        for (int k = 0; k < 256; k++) chk("t2_storage", mrd(7 * 256 + k), 16'h1000 + 16'(k));

        set_mode(1);
        run(1, 0, 0);
        chk("t3_strobes", last_words, 256);
        for (int k = 0; k < 256; k++) chk("t3_data", rbuf[k], 16'(k) ^ 16'h3C3C);

        set_mode(0);
        for (int k = 0; k < 256; k++) wbuf[k] = 16'h5000 ^ 16'(k);
        target = ndone + 1;
        @(posedge clk_sys); #1;
        sd_rd = 1; sd_wr = 1; sd_lba = 5;
        wait_ack();
        sd_rd = 0;
        wait_done(target);
        chk("t4_read_wins", last_kind, 1);
        wait_ack();
        sd_wr = 0;
        wait_done(target + 1);
        chk("t4_then_write", last_kind, 0);
        chk("t4_ack_gap", last_gap, 1);
        for (int k = 0; k < 256; k++) chk("t4_storage", mrd(5 * 256 + k), 16'h5000 ^ 16'(k));

        for (int k = 0; k < 256; k++) wbuf[k] = 16'($urandom);
        @(posedge clk_sys); #1;
        sd_wr = 1; sd_lba = 11;
        wait_ack();
        sd_wr = 0;
        n = 0;
        while (wk < 100 && n < 2000) begin @(posedge clk_sys); #1; n++; end
        chk("t5_word100", wk >= 100, 1);
        #2;
        reset_n = 0;
        #1;
        chk("t5_async_ack", sd_ack, 0);
        chk("t5_async_st_wr", st_wr, 0);
        chk("t5_async_strobe", sd_buff_wr, 0);
        chk("t5_async_addr", {sd_buff_addr, st_addr}, 0);
        save = ndone;
        repeat (3) @(posedge clk_sys);
        #1;
        reset_n = 1;
        repeat (20) @(posedge clk_sys);
        #1;
        chk("t5_idle_ack", sd_ack, 0);
        chk("t5_idle_req", {st_rd, st_wr}, 0);
        chk("t5_no_transfer", ndone, save);

`ifdef SD_RESP_BOUNDS_EN
        size_sectors = 4;
        run(1, 0, 4);
        chk("t6_rd_no_st_rd", last_nreq, 0);
        chk("t6_rd_strobes", last_words, 256);
        for (int k = 0; k < 256; k++) chk("t6_zero_data", rbuf[k], 0);
        run(0, 1, 9);
        chk("t6_wr_no_st_wr", last_nreq, 0);
`endif

        for (int i = 0; i < 12; i++) begin
            set_mode(int'($urandom_range(0, 2)));
            r = 1'($urandom_range(0, 1));
`ifdef SD_RESP_BOUNDS_EN
            l = $urandom_range(0, 8);
            exp_oor = l >= 32'(size_sectors);
`else
            l = $urandom;
            exp_oor = 0;
`endif
            for (int k = 0; k < 256; k++) wbuf[k] = 16'($urandom);
            run(r, !r, l);
            chk("rnd_kind", last_kind, r);
            chk("rnd_requests", last_nreq, exp_oor ? 0 : 256);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
